// File: rtl/buffer_o.sv
// Output buffer: captures MMU result columns into BUFFER_COUNT slots and streams them out element by element.
// Optional `last` output enabled by defining BUFFER_O_LAST_EN.
module buffer_o #(
    parameter  int VAR_SIZE     = 8,
    parameter  int MMU_SIZE     = 10,
    parameter  int BUFFER_COUNT = 32,
    localparam int BUF_W        = $clog2(BUFFER_COUNT),
    localparam int DIM_W        = $clog2(MMU_SIZE + 1),
    localparam int IDX_W        = $clog2(MMU_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cmd,
    input  logic [BUF_W-1:0]             buffer,
    input  logic [DIM_W-1:0]             dim_x_in,
    input  logic [DIM_W-1:0]             dim_y_in,
    input  logic                         stop,
    input  logic [VAR_SIZE*MMU_SIZE-1:0] A,
    output logic signed [VAR_SIZE-1:0]   B,
    output logic                         valid,
    output logic                         busy,
    output logic                         done,
    output logic [DIM_W-1:0]             dim_x,
    output logic [DIM_W-1:0]             dim_y
`ifdef BUFFER_O_LAST_EN
    ,
    output logic                         last
`endif
);

    // State encoding equals the command encoding, so IDLE can jump straight to state_t'(cmd).
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SEND  = 2'b10,
        S_CLEAR = 2'b11
    } state_t;

    state_t state, state_next;

    logic [BUF_W-1:0]             slot;
    logic [DIM_W-1:0]             ld_dx, ld_dy;
    logic [DIM_W-1:0]             col, row;
    logic [VAR_SIZE-1:0]          b_q;
    logic                         valid_q, last_q, done_q;
    logic [DIM_W-1:0]             dim_x_q, dim_y_q;

    logic [VAR_SIZE*MMU_SIZE-1:0] mem [BUFFER_COUNT][MMU_SIZE];
    logic [DIM_W-1:0]             mem_dx [BUFFER_COUNT];
    logic [DIM_W-1:0]             mem_dy [BUFFER_COUNT];

    logic                         col_we, dims_we, finish;
    logic [VAR_SIZE*MMU_SIZE-1:0] col_data, a_masked, send_col;
    logic [DIM_W-1:0]             dims_x, dims_y, send_dx, send_dy;
    logic [VAR_SIZE-1:0]          send_elem;

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        return (int'(d) > MMU_SIZE) ? DIM_W'(MMU_SIZE) : d;
    endfunction

    assign send_dx   = mem_dx[slot];
    assign send_dy   = mem_dy[slot];
    assign send_col  = mem[slot][col[IDX_W-1:0]];
    assign send_elem = send_col[int'(row)*VAR_SIZE +: VAR_SIZE];

    // Rows at or beyond the loaded row count are stored as zero.
    always_comb begin
        a_masked = A;
        for (int j = 0; j < MMU_SIZE; j++) begin
            if (j >= int'(ld_dy)) a_masked[VAR_SIZE*j +: VAR_SIZE] = '0;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        col_we     = 1'b0;
        col_data   = '0;
        dims_we    = 1'b0;
        dims_x     = ld_dx;
        dims_y     = ld_dy;
        finish     = 1'b0;
        if (!stop) begin
            unique case (state)
                S_IDLE: state_next = state_t'(cmd);
                S_LOAD: begin
                    if (ld_dx == '0 || ld_dy == '0) begin
                        finish = 1'b1;
                    end else begin
                        col_we   = 1'b1;
                        col_data = a_masked;
                        finish   = (col == ld_dx - DIM_W'(1));
                    end
                    dims_we = finish;
                end
                S_SEND: finish = (send_dx == '0) || (send_dy == '0) || (valid_q && last_q);
                S_CLEAR: begin
                    col_we = 1'b1;
                    if (col == DIM_W'(MMU_SIZE - 1)) begin
                        finish  = 1'b1;
                        dims_we = 1'b1;
                        dims_x  = '0;
                        dims_y  = '0;
                    end
                end
            endcase
            if (finish) state_next = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            slot    <= '0;
            ld_dx   <= '0;
            ld_dy   <= '0;
            col     <= '0;
            row     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            dim_x_q <= '0;
            dim_y_q <= '0;
        end else if (!stop) begin
            state  <= state_next;
            done_q <= finish;
            case (state)
                S_IDLE: begin
                    col <= '0;
                    row <= '0;
                    if (cmd != 2'b00) begin
                        slot  <= buffer;
                        ld_dx <= clamp_dim(dim_x_in);
                        ld_dy <= clamp_dim(dim_y_in);
                    end
                end
                S_LOAD, S_CLEAR: col <= col + DIM_W'(1);
                S_SEND: begin
                    dim_x_q <= send_dx;
                    dim_y_q <= send_dy;
                    if (finish) begin
                        b_q     <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        b_q     <= send_elem;
                        valid_q <= 1'b1;
                        last_q  <= (row == send_dy - DIM_W'(1)) && (col == send_dx - DIM_W'(1));
                        if (row == send_dy - DIM_W'(1)) begin
                            row <= '0;
                            col <= col + DIM_W'(1);
                        end else begin
                            row <= row + DIM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: slot storage is deliberately not reset; reset only blocks the write in progress.
    always_ff @(posedge clk) begin
        if (!rst && col_we) mem[slot][col[IDX_W-1:0]] <= col_data;
        if (!rst && dims_we) begin
            mem_dx[slot] <= dims_x;
            mem_dy[slot] <= dims_y;
        end
    end

    assign B     = b_q;
    assign valid = valid_q;
    assign busy  = (state != S_IDLE);
    assign done  = done_q & ~stop;
    assign dim_x = dim_x_q;
    assign dim_y = dim_y_q;
`ifdef BUFFER_O_LAST_EN
    assign last  = last_q;
`endif

endmodule
